player_controller: RTL and testbench
====================================

// Module: player_controller
// PURPOSE
//  Per-player motion stage feeding color_mapper's P1X/P1Y (or P2X/P2Y) inputs.
//  Converts held direction keys into tile-aligned hops on a 40x30 grid of 16px tiles.
//  Each hop is animated over several frames, stepping once per VGA frame tick.
//  Two instances are used, one per player, differing only in START_X/START_Y.
// PARAMETERS
//  START_X       10'd304  spawn/reset X, top-left pixel of sprite (tile-aligned)
//  START_Y       10'd448  spawn/reset Y (tile-aligned)
//  HOP_PX        4'd2     pixels moved per frame tick during a hop
//  HOP_FRAMES    4'd8     frame ticks per hop; HOP_PX*HOP_FRAMES must equal 16
//  X_MAX         10'd624  largest legal X (640-16); smallest legal X is 0
//  Y_MAX         10'd464  largest legal Y (480-16); smallest legal Y is 0
// PORTS
//  Clk        in   1   system clock (50 MHz)
//  Reset      in   1   asynchronous, active-high reset
//  frame_clk  in   1   VGA vsync, asynchronous to Clk
//  key_up     in   1   direction held, level (from keycode decoder)
//  key_down   in   1   direction held, level
//  key_left   in   1   direction held, level
//  key_right  in   1   direction held, level
//  respawn    in   1   single-cycle pulse from collision logic: return to spawn
//  PX         out  10  sprite X to color_mapper
//  PY         out  10  sprite Y to color_mapper
//  facing     out  2   00 up, 01 down, 10 left, 11 right (sprite frame select)
//  moving     out  1   high while a hop is in progress
// BEHAVIOUR
//  Reset (async): PX=START_X, PY=START_Y, facing=00, moving=0, state=IDLE, tick sync flops=0.
//  Frame tick: frame_clk passes through a 2-flop synchroniser; tick is a 1-cycle pulse
//   on a synchronised rising edge. tick is asserted 3 Clk edges after the frame_clk rise.
//  Direction select: up > down > left > right when several keys are held; none -> no request.
//  FSM IDLE: on tick with a request: facing <= dir (same cycle). If the target tile
//   (PX/PY +/-16) is within [0,X_MAX]x[0,Y_MAX], go to HOP, moving<=1, step count<=0.
//   If the target is out of bounds, update facing only and stay in IDLE (no wrap-around).
//  FSM HOP: on each tick, PX/PY += or -= HOP_PX in the facing direction, and count++.
//   When count reaches HOP_FRAMES-1 on a tick, take the final step, return to IDLE and
//   set moving<=0. PX/PY change only on tick cycles, 1 Clk after tick (registered).
//   Keys are ignored during HOP.
//  Back-to-back: a key still held at the first tick in IDLE starts the next hop, so
//   continuous travel is 16px per HOP_FRAMES+1 frames.
//  Arithmetic: 10-bit unsigned. Bounds are checked at hop start, so no intermediate
//   position underflows or leaves the legal range. PX and PY stay multiples of HOP_PX,
//   and are multiples of 16 whenever state is IDLE.
//  respawn: takes effect on the next Clk edge regardless of tick or state. It sets
//   PX/PY to START, facing=00, moving=0, state=IDLE and clears any buffered request.
//   respawn wins over a simultaneous tick.
//  Reset mid-hop: async return to the reset values; the partial hop is discarded.
// CONFIGURATION
//  HOP_BUFFER_EN defined: a 1-entry direction buffer. A request seen on any tick during
//   HOP is latched (last one wins). On the tick that ends the hop, a valid buffered
//   request is evaluated as if in IDLE, and the next hop starts on the following tick
//   with no gap frame. An out-of-bounds buffered request updates facing only. The buffer
//   clears when used and on respawn/Reset.
//  HOP_BUFFER_EN undefined: no buffer; keys during HOP are dropped (behaviour above).
// TESTING
//  Reset asserted mid-hop at PX=308 -> PX=304, PY=448, facing=00, moving=0 immediately.
//  key_up held, 9 ticks from IDLE (304,448) -> PY 446,444,...,432, moving 1 for 8 ticks,
//   then 0, with PX=304 throughout.
//  key_down at PY=464 -> facing=01, PY stays 464, moving stays 0.
//  key_left and key_right held together at PX=0 -> facing=10, no move; key_up added -> hop up.
//  respawn pulse coincident with a tick at step 5 of a right hop -> PX=304, PY=448,
//   state IDLE.
//  HOP_BUFFER_EN: key_left tapped during step 3 of an up hop -> left hop begins on the
//   tick after landing; without the macro, no left hop occurs.

Source files
------------

// File: rtl/player_controller.sv
// player_controller
//   Motion stage for one player sprite. Held direction keys become 16px,
//   tile-aligned hops on the 40x30 playfield. Each hop is animated over
//   HOP_FRAMES VGA frame ticks, moving HOP_PX pixels per tick.
//
// Ports
//   Clk, Reset      system clock / asynchronous active-high reset
//   frame_clk       VGA vsync (asynchronous to Clk), source of the frame tick
//   key_up/down/left/right  held direction levels (priority up>down>left>right)
//   respawn         1-cycle pulse: return to spawn, abort any hop
//   PX, PY          sprite top-left pixel position
//   facing          00 up, 01 down, 10 left, 11 right
//   moving          high while a hop is in progress
//
// Build option
//   HOP_BUFFER_EN   when defined, adds a 1-entry direction buffer so that a key
//                   seen during a hop chains straight into the next hop.
module player_controller #(
  parameter logic [9:0] START_X    = 10'd304,
  parameter logic [9:0] START_Y    = 10'd448,
  parameter logic [3:0] HOP_PX     = 4'd2,
  parameter logic [3:0] HOP_FRAMES = 4'd8,
  parameter logic [9:0] X_MAX      = 10'd624,
  parameter logic [9:0] Y_MAX      = 10'd464
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       respawn,
  output logic [9:0] PX,
  output logic [9:0] PY,
  output logic [1:0] facing,
  output logic       moving
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [9:0] TILE      = 10'd16;
  localparam logic [9:0] STEP      = {6'd0, HOP_PX};

  typedef enum logic {IDLE, HOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;

  // ---------------------------------------------------------------------
  // Frame tick: 2-flop synchroniser, a history flop for edge detection and
  // a registered pulse (high for one cycle, 3 Clk edges after the rise).
  // ---------------------------------------------------------------------
  logic fc_s0, fc_s1, fc_s2, tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_s0 <= 1'b0;
      fc_s1 <= 1'b0;
      fc_s2 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      fc_s0 <= frame_clk;
      fc_s1 <= fc_s0;
      fc_s2 <= fc_s1;
      tick  <= fc_s1 & ~fc_s2;
    end
  end

  // ---------------------------------------------------------------------
  // Direction request with fixed priority
  // ---------------------------------------------------------------------
  logic       req_vld;
  logic [1:0] req_dir;

  always_comb begin
    req_vld = key_up | key_down | key_left | key_right;
    req_dir = DIR_RIGHT;
    if      (key_up)   req_dir = DIR_UP;
    else if (key_down) req_dir = DIR_DOWN;
    else if (key_left) req_dir = DIR_LEFT;
  end

  // True when a full tile hop from (x,y) in direction d stays on the field.
  // Checking once at hop start keeps every intermediate step in range.
  function automatic logic fits(input logic [1:0] d, input logic [9:0] x,
                                input logic [9:0] y);
    case (d)
      DIR_UP:   fits = (y >= TILE);
      DIR_DOWN: fits = (y <= Y_MAX - TILE);
      DIR_LEFT: fits = (x >= TILE);
      default:  fits = (x <= X_MAX - TILE);
    endcase
  endfunction

  // Position after one animation step in the current facing direction
  logic [9:0] step_x, step_y;

  always_comb begin
    step_x = PX;
    step_y = PY;
    case (facing)
      DIR_UP:    step_y = PY - STEP;
      DIR_DOWN:  step_y = PY + STEP;
      DIR_LEFT:  step_x = PX - STEP;
      default:   step_x = PX + STEP;
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional direction buffer. The request on the landing tick itself takes
  // precedence over an older buffered one (last one wins).
  // ---------------------------------------------------------------------
  logic       eff_vld;
  logic [1:0] eff_dir;
  logic       chain_ok;

`ifdef HOP_BUFFER_EN
  logic       buf_vld;
  logic [1:0] buf_dir;

  always_comb begin
    eff_vld  = req_vld | buf_vld;
    eff_dir  = req_vld ? req_dir : buf_dir;
    // Bounds are judged from the landing tile, i.e. after the final step.
    chain_ok = eff_vld & fits(eff_dir, step_x, step_y);
  end
`else
  always_comb begin
    eff_vld  = 1'b0;
    eff_dir  = DIR_UP;
    chain_ok = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs + control strobes
  // ---------------------------------------------------------------------
  logic idle_req, start_hop, hop_step, last_step, hop_end;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (respawn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_hop) state_nxt = HOP;
        HOP:     if (hop_end && !chain_ok) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    moving    = (state == HOP);
    last_step = (cnt == HOP_FRAMES - 4'd1);
    idle_req  = tick & (state == IDLE) & req_vld;
    start_hop = idle_req & fits(req_dir, PX, PY);
    hop_step  = tick & (state == HOP);
    hop_end   = hop_step & last_step;
  end

  // ---------------------------------------------------------------------
  // Position / facing / step counter. respawn outranks any tick.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PX     <= START_X;
      PY     <= START_Y;
      facing <= DIR_UP;
      cnt    <= 4'd0;
    end else if (respawn) begin
      PX     <= START_X;
      PY     <= START_Y;
      facing <= DIR_UP;
      cnt    <= 4'd0;
    end else if (idle_req) begin
      // Facing turns even when the hop is refused at the edge.
      facing <= req_dir;
      cnt    <= 4'd0;
    end else if (hop_step) begin
      PX <= step_x;
      PY <= step_y;
      if (last_step) begin
        cnt <= 4'd0;
        if (eff_vld) facing <= eff_dir;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

`ifdef HOP_BUFFER_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf_vld <= 1'b0;
      buf_dir <= DIR_UP;
    end else if (respawn) begin
      buf_vld <= 1'b0;
      buf_dir <= DIR_UP;
    end else if (hop_step) begin
      if (last_step) begin
        buf_vld <= 1'b0;
      end else if (req_vld) begin
        buf_vld <= 1'b1;
        buf_dir <= req_dir;
      end
    end
  end
`endif

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller. Each frame tick is produced by a
// full frame_clk pulse; outputs are sampled on the falling edge of Clk.
module tb_player_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       respawn = 1'b0;
  logic [9:0] PX, PY;
  logic [1:0] facing;
  logic       moving;

  int n_cmp = 0;
  int n_err = 0;

  player_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .respawn(respawn),
    .PX(PX), .PY(PY), .facing(facing), .moving(moving)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: tick pulses 3 edges after the rise and is consumed on the 4th.
  // With rsp set, respawn is high in exactly the cycle where tick is high.
  task automatic do_tick(input bit rsp);
    @(negedge Clk); frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    if (rsp) respawn = 1'b1;
    @(negedge Clk); respawn = 1'b0;
    @(negedge Clk); frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic keys(input bit u, input bit d, input bit l, input bit r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  // Start a hop with one key pressed for the start tick, then run it out.
  task automatic full_hop(input bit u, input bit d, input bit l, input bit r);
    keys(u, d, l, r);
    do_tick(0);
    keys(0, 0, 0, 0);
    repeat (8) do_tick(0);
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_px", 32'(PX), 304);
    chk("rst_py", 32'(PY), 448);
    chk("rst_facing", 32'(facing), 0);
    chk("rst_moving", 32'(moving), 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Up hop: start tick, then 8 steps of 2px
    keys(1, 0, 0, 0);
    do_tick(0);
    keys(0, 0, 0, 0);
    chk("up_start_py", 32'(PY), 448);
    chk("up_start_moving", 32'(moving), 1);
    chk("up_start_facing", 32'(facing), 0);
    for (int k = 1; k <= 8; k++) begin
      do_tick(0);
      chk($sformatf("up_step%0d_py", k), 32'(PY), 32'(448 - 2 * k));
      chk($sformatf("up_step%0d_px", k), 32'(PX), 304);
      chk($sformatf("up_step%0d_moving", k), 32'(moving), (k == 8) ? 0 : 1);
    end

    // Reset asserted mid-hop at PX=308
    keys(0, 0, 0, 1);
    do_tick(0);
    keys(0, 0, 0, 0);
    do_tick(0);
    do_tick(0);
    chk("mid_px", 32'(PX), 308);
    chk("mid_facing", 32'(facing), 3);
    #2 Reset = 1'b1;
    #1;
    chk("arst_px", 32'(PX), 304);
    chk("arst_py", 32'(PY), 448);
    chk("arst_facing", 32'(facing), 0);
    chk("arst_moving", 32'(moving), 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Down to the bottom row, then a down request is refused
    full_hop(0, 1, 0, 0);
    chk("down_land_py", 32'(PY), 464);
    keys(0, 1, 0, 0);
    do_tick(0);
    do_tick(0);
    keys(0, 0, 0, 0);
    chk("down_oob_py", 32'(PY), 464);
    chk("down_oob_facing", 32'(facing), 1);
    chk("down_oob_moving", 32'(moving), 0);

    // Walk left to the field edge: 19 hops from 304
    for (int h = 0; h < 19; h++) full_hop(0, 0, 1, 0);
    chk("left_edge_px", 32'(PX), 0);
    chk("left_edge_moving", 32'(moving), 0);

    // left+right at PX=0: left wins, refused, facing turns
    full_hop(0, 0, 0, 1);   // face right first so the turn is observable
    full_hop(0, 0, 1, 0);   // and come back to PX=0
    chk("back_edge_px", 32'(PX), 0);
    keys(0, 0, 1, 1);
    do_tick(0);
    chk("lr_facing", 32'(facing), 2);
    chk("lr_px", 32'(PX), 0);
    chk("lr_moving", 32'(moving), 0);
    // up added: up has priority and hops
    keys(1, 0, 1, 1);
    do_tick(0);
    keys(0, 0, 0, 0);
    chk("lru_facing", 32'(facing), 0);
    chk("lru_moving", 32'(moving), 1);
    repeat (8) do_tick(0);
    chk("lru_land_py", 32'(PY), 448);
    chk("lru_land_px", 32'(PX), 0);

    // Right hop, respawn coincident with the step-5 tick
    keys(0, 0, 0, 1);
    do_tick(0);
    keys(0, 0, 0, 0);
    repeat (4) do_tick(0);
    chk("rsp_pre_px", 32'(PX), 8);
    do_tick(1);
    chk("rsp_px", 32'(PX), 304);
    chk("rsp_py", 32'(PY), 448);
    chk("rsp_facing", 32'(facing), 0);
    chk("rsp_moving", 32'(moving), 0);
    do_tick(0);
    chk("rsp_idle_px", 32'(PX), 304);
    chk("rsp_idle_moving", 32'(moving), 0);

    // Left tapped on step 3 of an up hop
    keys(1, 0, 0, 0);
    do_tick(0);
    keys(0, 0, 0, 0);
    do_tick(0);
    do_tick(0);
    keys(0, 0, 1, 0);
    do_tick(0);
    keys(0, 0, 0, 0);
    repeat (5) do_tick(0);
    chk("tap_land_py", 32'(PY), 432);
    chk("tap_land_px", 32'(PX), 304);
    do_tick(0);
`ifdef HOP_BUFFER_EN
    chk("tap_next_px", 32'(PX), 302);
    chk("tap_next_moving", 32'(moving), 1);
    chk("tap_next_facing", 32'(facing), 2);
`else
    chk("tap_next_px", 32'(PX), 304);
    chk("tap_next_moving", 32'(moving), 0);
    chk("tap_next_facing", 32'(facing), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
